seg_scan: RTL and testbench
===========================

# seg_scan

Time-multiplexed seven-segment display scanner sitting directly downstream of the LFSR/counter stages: it captures a hex value on a load strobe and drives a shared segment bus plus per-digit anode enables, one digit per scan slot. Updates are frame-synchronous, so a value never tears across digits. It replaces per-digit static decoding where board pins are shared.

## Interface
- NUM_DIGITS, 4, number of hex digits scanned (≥2).
- SCAN_DIV, 1000, clk cycles per digit slot (≥2).
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe; captures data into shadow register.
- data  in  4*NUM_DIGITS  hex value; nibble i → digit i (digit 0 = least significant).
- clear  in  1  level; blanks the display while high.
- seg  out  7  active-low segments; seg[0]=a … seg[6]=g.
- an  out  NUM_DIGITS  active-low digit enables; at most one low.
- frame_done  out  1  one-cycle pulse at end of each full scan.

## Operation
- Prescaler cnt counts 0..SCAN_DIV-1. At cnt==SCAN_DIV-1: cnt←0 and idx←idx+1, wrapping NUM_DIGITS-1→0.
- Frame end = cycle where cnt==SCAN_DIV-1 and idx==NUM_DIGITS-1. frame_done is registered and is high the cycle after the frame end.
- load=1: shadow←data and pending←1. A later load before the frame end overwrites shadow (last write wins).
- At frame end with pending=1: disp←shadow, pending←0.
- load on the frame-end cycle itself bypasses shadow: disp←data that cycle and pending←0.
- Decode is hex 0–F, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Outputs are registered from idx, disp and clear:
  - an has bit idx low and all other bits high.
  - seg=decode(disp nibble idx).
- clear=1: on the next cycle seg=7'h7F and an=all ones. cnt, idx, frame_done and load capture are unaffected.
- Reset values: cnt=0, idx=0, disp=0, shadow=0, pending=0, seg=7'h7F, an=all ones, frame_done=0.
- rst mid-frame: everything returns to reset values. A load in the same cycle as rst is dropped.

## Timing
- Output latency from idx/disp change to seg/an is 1 cycle.
- In the first cycle after rst deasserts, outputs are still at reset values. From the second cycle, an[0]=0 and seg shows digit 0 of disp.
- Each digit stays active for exactly SCAN_DIV cycles. A frame lasts NUM_DIGITS*SCAN_DIV cycles, so frame_done has a fixed period of NUM_DIGITS*SCAN_DIV.
- Latency from load to display is at most one frame plus 1 cycle. New data first appears in the digit-0 slot after the next frame_done.

## Configuration
- SEG_SCAN_LZB_EN defined enables leading-zero blanking:
  - Digit i>0 is blanked when nibbles i..NUM_DIGITS-1 of disp are all zero.
  - A blanked slot keeps its timing, with an=all ones and seg=7'h7F.
  - Digit 0 is never blanked.
- SEG_SCAN_LZB_EN undefined: every digit is always shown, including zeros.

## Structure
- Package seg_pkg holds:
  - the 16-entry active-low hex segment constants;
  - SEG_BLANK=7'h7F;
  - a typedef for the 7-bit segment vector.
- Sub-module seg_hex_decode: combinational nibble→segment lookup built from the seg_pkg constants.
- seg_scan holds the prescaler, digit index, shadow/disp/pending registers, LZB logic and output registers.

## Test plan
All scenarios use NUM_DIGITS=2, SCAN_DIV=4.
- Reset: hold rst 3 cycles.
  - During reset and the first cycle after release: seg=7F, an=11, frame_done=0.
  - Next cycle: an=10, seg=1000000.
  - frame_done pulses every 8 cycles.
- Mid-frame load of 8'h3A:
  - Display stays 00 until frame_done.
  - Following slot: an=10, seg=0001000 ("A").
  - After 4 cycles: an=01, seg=0110000 ("3").
- Load of 8'h12 then 8'h34 in the same frame: next frame shows 34; 12 is never displayed.
- Load of 8'hF0 on the frame-end cycle: the very next frame shows 0 then F (seg=0001110).
- clear high for 6 cycles mid-slot:
  - seg=7F and an=11 from the next cycle until 1 cycle after clear falls.
  - frame_done cadence is unchanged.
- With SEG_SCAN_LZB_EN, load 8'h05: the digit-1 slot gives an=11, seg=7F, and the digit-0 slot gives seg=0010010. Without the macro, digit 1 shows 1000000.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment scanner.
//   seg_t     - 7-bit active-low segment vector, bit 0 = a ... bit 6 = g
//   SEG_BLANK - all segments off
//   HEX_SEG   - active-low segment patterns for hex digits 0..F,
//               indexed by the nibble value (HEX_SEG[n] is digit n)
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Packed array: the first element listed is index 15, the last is index 0.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to active-low segment lookup.
// Ports:
//   nibble  in  4  hex value 0..F
//   seg     out 7  active-low segments, seg[0]=a ... seg[6]=g
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed seven-segment scanner with frame-synchronous
// display update.
// Parameters:
//   NUM_DIGITS  number of hex digits scanned (>= 2)
//   SCAN_DIV    clk cycles per digit slot (>= 2)
// Ports:
//   clk         in   clock
//   rst         in   synchronous, active-high reset
//   load        in   one-cycle strobe, captures data into the shadow register
//   data        in   hex value, nibble i drives digit i (digit 0 = LSN)
//   clear       in   level, blanks the display while high
//   seg         out  active-low segments, seg[0]=a ... seg[6]=g
//   an          out  active-low digit enables, at most one low
//   frame_done  out  one-cycle pulse after the last slot of each scan
// Configuration:
//   SEG_SCAN_LZB_EN  when defined, leading zero digits (other than digit 0)
//                    are blanked; when undefined every digit is shown.
module seg_scan
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic                    clear,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [DW-1:0]         shadow;
  logic [DW-1:0]         disp;
  logic                  pending;

  logic                  slot_end;
  logic                  frame_end;
  logic [3:0]            cur_nib;
  seg_t                  cur_seg;
  logic [NUM_DIGITS-1:0] an_sel;
  logic                  blank;

  assign slot_end  = (cnt == CW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx == IW'(NUM_DIGITS - 1));

  assign cur_nib = disp[{idx, 2'b00} +: 4];
  assign an_sel  = ~(NUM_DIGITS'(1) << idx);

`ifdef SEG_SCAN_LZB_EN
  // A digit above 0 is a leading zero when it and every higher nibble are 0.
  assign blank = (idx != '0) && ((disp >> {idx, 2'b00}) == '0);
`else
  assign blank = 1'b0;
`endif

  seg_hex_decode u_dec (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      disp       <= '0;
      pending    <= 1'b0;
      seg        <= SEG_BLANK;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      frame_done <= frame_end;

      // A load landing on the frame-end cycle goes straight to the display,
      // otherwise it waits in shadow until the next frame boundary.
      if (load && frame_end) begin
        disp    <= data;
        pending <= 1'b0;
      end else if (load) begin
        shadow  <= data;
        pending <= 1'b1;
      end else if (frame_end && pending) begin
        disp    <= shadow;
        pending <= 1'b0;
      end

      if (clear || blank) begin
        seg <= SEG_BLANK;
        an  <= '1;
      end else begin
        seg <= cur_seg;
        an  <= an_sel;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: scoreboard bench for seg_scan with NUM_DIGITS=2, SCAN_DIV=4.
// The stimulus side computes the expected outputs from elapsed-time
// arithmetic and pushes them into a queue; the monitor pops one entry per
// clock and compares it with the DUT outputs.
module tb_seg_scan;

  localparam int ND    = 2;
  localparam int SD    = 4;
  localparam int DW    = 4 * ND;
  localparam int FRAME = ND * SD;

  logic          clk = 1'b1;
  logic          rst;
  logic          load;
  logic          clear;
  logic [DW-1:0] data;
  logic [6:0]    seg;
  logic [ND-1:0] an;
  logic          frame_done;

  seg_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data       (data),
    .clear      (clear),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic          fd;
  } exp_t;

  exp_t exp_q[$];

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model: mk = clock cycles elapsed since reset released.
  int            mk;
  logic [DW-1:0] m_disp;
  logic [DW-1:0] m_shadow;
  logic          m_pending;

  int vectors     = 0;
  int miscompares = 0;
  int mon_cycle   = 0;

  task automatic applyStimulus(input logic r, input logic l,
                               input logic [DW-1:0] d, input logic c);
    exp_t       e;
    int         slot;
    bit         fe;
    bit         blank;
    logic [3:0] nib;
    rst   = r;
    load  = l;
    data  = d;
    clear = c;
    if (r) begin
      e.seg     = 7'h7F;
      e.an      = '1;
      e.fd      = 1'b0;
      mk        = 0;
      m_disp    = '0;
      m_shadow  = '0;
      m_pending = 1'b0;
    end else begin
      slot  = (mk / SD) % ND;
      fe    = ((mk % FRAME) == FRAME - 1);
      blank = 1'b0;
`ifdef SEG_SCAN_LZB_EN
      blank = (slot > 0) && ((m_disp >> (4 * slot)) == '0);
`endif
      nib = 4'(m_disp >> (4 * slot));
      if (c || blank) begin
        e.seg = 7'h7F;
        e.an  = '1;
      end else begin
        e.seg = hex_tab[nib];
        e.an  = ~(ND'(1) << slot);
      end
      e.fd = fe;
      if (l && fe) begin
        m_disp    = d;
        m_pending = 1'b0;
      end else if (l) begin
        m_shadow  = d;
        m_pending = 1'b1;
      end else if (fe && m_pending) begin
        m_disp    = m_shadow;
        m_pending = 1'b0;
      end
      mk++;
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, '0, 1'b0);
  endtask

  // Idle until the next applied cycle sits at the given frame phase.
  task automatic syncTo(input int phase);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ((mk % FRAME) == phase) break;
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    if (seg !== e.seg || an !== e.an || frame_done !== e.fd) begin
      miscompares++;
      $display("[TB] FAIL out@%0d: got seg=%b an=%b frame_done=%b, want seg=%b an=%b frame_done=%b",
               mon_cycle, seg, an, frame_done, e.seg, e.an, e.fd);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      mon_cycle++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    int clr_left;
    bit r;
    bit l;
    bit c;
    logic [DW-1:0] d;
    rst   = 1'b1;
    load  = 1'b0;
    clear = 1'b0;
    data  = '0;
    mk    = 0;
    @(negedge clk);

    repeat (3) applyStimulus(1'b1, 1'b0, '0, 1'b0);
    idle(20);

    syncTo(2);
    applyStimulus(1'b0, 1'b1, 8'h3A, 1'b0);
    idle(20);

    syncTo(0);
    applyStimulus(1'b0, 1'b1, 8'h12, 1'b0);
    idle(1);
    applyStimulus(1'b0, 1'b1, 8'h34, 1'b0);
    idle(20);

    syncTo(FRAME - 1);
    applyStimulus(1'b0, 1'b1, 8'hF0, 1'b0);
    idle(20);

    syncTo(1);
    repeat (6) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    idle(10);

    applyStimulus(1'b0, 1'b1, 8'h05, 1'b0);
    idle(20);

    syncTo(3);
    applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0);
    idle(12);

    clr_left = 0;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 5) == 0);
      d = ($urandom_range(0, 2) == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom);
      if (clr_left == 0 && $urandom_range(0, 39) == 0) clr_left = $urandom_range(1, 6);
      c = (clr_left > 0);
      if (clr_left > 0) clr_left--;
      applyStimulus(r, l, d, c);
    end
    idle(4);

    repeat (2) @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
